// File: rtl/trig_pkg.sv
// Shared types and constants for the angle sequencer and its wrap adder.
package trig_pkg;

    localparam int unsigned THETA_W   = 10;
    localparam int unsigned TRIG_W    = 16;
    localparam int unsigned TABLE_LEN = 805;
    localparam int unsigned QUARTER   = 201;
    localparam int unsigned STEP_W    = 8;

    typedef logic        [THETA_W-1:0] theta_t;
    typedef logic signed [TRIG_W-1:0]  trig_t;
    typedef logic signed [11:0]        delta_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UPDATE,
        S_RD_COS,
        S_RD_SIN,
        S_HOLD
    } seq_state_e;

    localparam theta_t TABLE_LEN_T  = theta_t'(TABLE_LEN);
    localparam delta_t TABLE_LEN_D  = delta_t'(TABLE_LEN);
    localparam delta_t NEG_QUARTER  = delta_t'(-int'(QUARTER));

    // Loaded angles only need one subtract: 10-bit inputs are below 2*805.
    function automatic theta_t load_reduce(input theta_t v);
        return (v >= TABLE_LEN_T) ? theta_t'(v - TABLE_LEN_T) : v;
    endfunction

endpackage

// File: rtl/angle_wrap.sv
// Combinational modular adder: y = (a + delta) mod TABLE_LEN for |delta| < TABLE_LEN.
module angle_wrap
    import trig_pkg::*;
(
    input  theta_t a,
    input  delta_t delta,
    output theta_t y
);

    logic signed [11:0] w_sum;
    logic signed [11:0] w_res;

    always_comb begin
        w_sum = $signed({2'b00, a}) + delta;
        if (w_sum < 12'sd0) begin
            w_res = w_sum + TABLE_LEN_D;
        end else if (w_sum >= TABLE_LEN_D) begin
            w_res = w_sum - TABLE_LEN_D;
        end else begin
            w_res = w_sum;
        end
        y = w_res[THETA_W-1:0];
    end

endmodule

// File: rtl/angle_sequencer.sv
// Per-frame angle advance, then two cos-ROM reads (cos, shifted cos = sin)
// presented downstream as a valid/ready pair.
module angle_sequencer
    import trig_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_tick,
    input  logic [STEP_W-1:0] omega,
    input  logic              load_en,
    input  theta_t            load_theta,
    output theta_t            rom_theta,
    input  trig_t             rom_out,
    output theta_t            theta,
    output trig_t             cos_val,
    output trig_t             sin_val,
    output logic              pair_valid,
    input  logic              pair_ready,
    output logic              busy,
    output logic              overrun
);

    seq_state_e r_state;
    seq_state_e w_next;

    theta_t r_theta;
    theta_t r_rom_theta;
    theta_t r_sin_addr;
    trig_t  r_cos;
    trig_t  r_sin;
    logic   r_pending;
    logic   r_overrun;

    delta_t w_step;
    theta_t w_new_theta;
    theta_t w_sin_addr;

    assign w_step = {{(12-STEP_W){omega[STEP_W-1]}}, omega};

    angle_wrap u_step_wrap (
        .a     (r_theta),
        .delta (w_step),
        .y     (w_new_theta)
    );

    // sin address is derived from the freshly advanced angle, not the old one
    angle_wrap u_quarter_wrap (
        .a     (w_new_theta),
        .delta (NEG_QUARTER),
        .y     (w_sin_addr)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (frame_tick || r_pending) w_next = S_UPDATE;
            S_UPDATE: w_next = S_RD_COS;
            S_RD_COS: w_next = S_RD_SIN;
            S_RD_SIN: w_next = S_HOLD;
            S_HOLD:   if (pair_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= S_IDLE;
            r_theta     <= '0;
            r_rom_theta <= '0;
            r_sin_addr  <= '0;
            r_cos       <= '0;
            r_sin       <= '0;
            r_pending   <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE) begin
                if (load_en) r_theta <= load_reduce(load_theta);
                if (frame_tick || r_pending) r_pending <= 1'b0;
            end else if (frame_tick) begin
                if (r_pending) r_overrun <= 1'b1;
                else           r_pending <= 1'b1;
            end
            // ROM address is loaded one cycle ahead of each read state
            case (r_state)
                S_UPDATE: begin
                    r_theta     <= w_new_theta;
                    r_sin_addr  <= w_sin_addr;
                    r_rom_theta <= w_new_theta;
                end
                S_RD_COS: begin
                    r_cos       <= rom_out;
                    r_rom_theta <= r_sin_addr;
                end
                S_RD_SIN: r_sin <= rom_out;
                default: ;
            endcase
        end
    end

    assign rom_theta  = r_rom_theta;
    assign theta      = r_theta;
    assign cos_val    = r_cos;
    assign sin_val    = r_sin;
    assign pair_valid = (r_state == S_HOLD);
    assign busy       = (r_state != S_IDLE);
    assign overrun    = r_overrun;

endmodule
